// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard /
//                forwarding controller.
//                - forwarding-mux select encodings for the ID/EXE qa/qb muxes
//                - scoreboard entry type {valid, wreg, m2reg, dest}
//                - helpers that decide whether a stage writes a register and
//                  which forwarding source an operand should use
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Forwarding select encodings (qa/qb mux in ID/EXE)
    localparam logic [1:0] FWD_RF   = 2'b00;  // register file
    localparam logic [1:0] FWD_EXE  = 2'b01;  // EXE-stage ALU result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_LOAD = 2'b11;  // MEM-stage load data

    // Width of the destination field held in the scoreboard. The top-level
    // REG_AW must not exceed this.
    localparam int SB_AW = 5;

    localparam logic [SB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic             m2reg;
        logic [SB_AW-1:0] dest;
    } sb_entry_t;

    // A stage "writes r" only for a real, register-writing instruction whose
    // destination matches; $0 is hard-wired and never produces a dependency.
    function automatic logic sb_writes(input sb_entry_t e, input logic [SB_AW-1:0] r);
        return e.valid && e.wreg && (e.dest == r) && (r != REG_ZERO);
    endfunction

    // Forwarding source for one operand. EXE has priority over MEM. A load
    // sitting in EXE cannot be forwarded (its data is not ready yet); that
    // case is covered by the load-use stall, so it falls through to MEM.
    function automatic logic [1:0] fwd_sel(input logic             use_op,
                                           input sb_entry_t        e,
                                           input sb_entry_t        m,
                                           input logic [SB_AW-1:0] r);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_op) begin
            if (sb_writes(e, r) && !e.m2reg) begin
                sel = FWD_EXE;
            end else if (sb_writes(m, r)) begin
                sel = m.m2reg ? FWD_LOAD : FWD_MEM;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb_stage
//  Description : One scoreboard pipeline register (E or M stage). Captures
//                an entry every clock, or all-zero when i_bubble is high.
//                Asynchronously cleared by resetn.
//  Ports       : clk      in   pipeline clock, rising edge
//                resetn   in   asynchronous active-low reset
//                i_bubble in   1 = load an empty entry this cycle
//                i_entry  in   entry to capture
//                o_entry  out  registered entry
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_sb_stage
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      i_bubble,
    input  sb_entry_t i_entry,
    output sb_entry_t o_entry
);

    sb_entry_t r_entry_q;
    sb_entry_t w_entry_d;

    always_comb begin
        w_entry_d = i_entry;
        if (i_bubble) begin
            w_entry_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_entry_q <= '0;
        end else begin
            r_entry_q <= w_entry_d;
        end
    end

    assign o_entry = r_entry_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard and forwarding controller for a 5-stage pipeline
//                (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB). Tracks in-flight
//                destinations (E, M) from ID decode info, stalls PC and
//                IF/ID for one cycle on a load-use hazard while bubbling
//                ID/EXE, and drives the qa/qb forwarding selects.
//  Ports       : clk, resetn          clock / async active-low reset
//                id_*                 ID-stage decode information
//                pc_we, ifid_we       write enables (0 = hold)
//                idexe_bubble         1 = NOP controls into ID/EXE
//                fwda, fwdb           forwarding selects (see hazard_pkg)
//                stall_count          saturating count of stall cycles
//                branch_taken (in), ifid_flush (out)
//                                     only with HAZARD_BRANCH_FLUSH_EN
//  Config      : HAZARD_BRANCH_FLUSH_EN - adds taken-branch flush handling
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_dest,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idexe_bubble,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic [CNT_W-1:0]  stall_count
`ifdef HAZARD_BRANCH_FLUSH_EN
    ,
    input  logic              branch_taken,
    output logic              ifid_flush
`endif
);

    sb_entry_t        w_e_entry;
    sb_entry_t        w_m_entry;
    sb_entry_t        w_id_entry;
    logic [SB_AW-1:0] w_rs;
    logic [SB_AW-1:0] w_rt;
    logic             w_use_rs;
    logic             w_use_rt;
    logic             w_raw_load_use;
    logic             w_load_use;
    logic             w_branch;
    logic             w_e_bubble;

    logic [CNT_W-1:0] r_stall_count_q;
    logic [CNT_W-1:0] w_stall_count_d;

`ifdef HAZARD_BRANCH_FLUSH_EN
    assign w_branch   = branch_taken;
    assign ifid_flush = branch_taken;
`else
    assign w_branch   = 1'b0;
`endif

    assign w_rs     = SB_AW'(id_rs);
    assign w_rt     = SB_AW'(id_rt);
    // An invalid ID slot reads nothing: no hazard and no forwarding.
    assign w_use_rs = id_valid & id_use_rs;
    assign w_use_rt = id_valid & id_use_rt;

    always_comb begin
        w_id_entry       = '0;
        w_id_entry.valid = id_valid;
        w_id_entry.wreg  = id_wreg;
        w_id_entry.m2reg = id_m2reg;
        w_id_entry.dest  = SB_AW'(id_dest);
    end

    // Load in EXE whose result the ID instruction needs. Combinational, so
    // an async reset that clears the scoreboard drops the stall at once.
    assign w_raw_load_use = w_e_entry.m2reg &
                            ((w_use_rs & sb_writes(w_e_entry, w_rs)) |
                             (w_use_rt & sb_writes(w_e_entry, w_rt)));

    // A taken branch squashes the ID instruction, so its dependency is moot
    // and the PC must advance to the branch target.
    assign w_load_use = w_raw_load_use & ~w_branch;

    assign pc_we        = ~w_load_use;
    assign ifid_we      = ~w_load_use;
    assign idexe_bubble = w_load_use | w_branch;

    assign fwda = fwd_sel(w_use_rs, w_e_entry, w_m_entry, w_rs);
    assign fwdb = fwd_sel(w_use_rt, w_e_entry, w_m_entry, w_rt);

    // E takes a bubble whenever ID/EXE gets NOP controls.
    assign w_e_bubble = w_load_use | w_branch | ~id_valid;

    hazard_sb_stage u_sb_e (
        .clk      (clk),
        .resetn   (resetn),
        .i_bubble (w_e_bubble),
        .i_entry  (w_id_entry),
        .o_entry  (w_e_entry)
    );

    hazard_sb_stage u_sb_m (
        .clk      (clk),
        .resetn   (resetn),
        .i_bubble (1'b0),
        .i_entry  (w_e_entry),
        .o_entry  (w_m_entry)
    );

    always_comb begin
        w_stall_count_d = r_stall_count_q;
        if (w_load_use && !(&r_stall_count_q)) begin
            w_stall_count_d = r_stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_count_q <= '0;
        end else begin
            r_stall_count_q <= w_stall_count_d;
        end
    end

    assign stall_count = r_stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Instruction
//                sequences are applied one per clock; the expected control
//                outputs for each are pushed to a queue when driven and
//                popped and compared once the combinational outputs settle.
//                A narrow stall counter is used so saturation is reachable.
//  Config      : HAZARD_BRANCH_FLUSH_EN - also exercises branch flush
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int TB_AW  = 5;
    localparam int TB_CNT = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             id_valid;
    logic [TB_AW-1:0] id_rs, id_rt, id_dest;
    logic             id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic             pc_we, ifid_we, idexe_bubble;
    logic [1:0]       fwda, fwdb;
    logic [TB_CNT-1:0] stall_count;
    logic             branch_taken;
`ifdef HAZARD_BRANCH_FLUSH_EN
    logic             ifid_flush;
`endif

    typedef struct {
        string             tag;
        logic              stall;
        logic [1:0]        fa;
        logic [1:0]        fb;
        logic [TB_CNT-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl #(.REG_AW(TB_AW), .CNT_W(TB_CNT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_wreg      (id_wreg),
        .id_m2reg     (id_m2reg),
        .id_dest      (id_dest),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idexe_bubble (idexe_bubble),
        .fwda         (fwda),
        .fwdb         (fwdb),
        .stall_count  (stall_count)
`ifdef HAZARD_BRANCH_FLUSH_EN
        ,
        .branch_taken (branch_taken),
        .ifid_flush   (ifid_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [TB_CNT-1:0] cnt);
        exp_t e;
        e.tag = tag; e.stall = st; e.fa = fa; e.fb = fb; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Let the combinational outputs settle, then compare against the oldest
    // outstanding expectation.
    task automatic pop_check();
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val({e.tag, ".pc_we"},   32'(pc_we),        32'(!e.stall));
        check_val({e.tag, ".ifid_we"}, 32'(ifid_we),      32'(!e.stall));
        check_val({e.tag, ".bubble"},  32'(idexe_bubble), 32'(e.stall));
        check_val({e.tag, ".fwda"},    32'(fwda),         32'(e.fa));
        check_val({e.tag, ".fwdb"},    32'(fwdb),         32'(e.fb));
        check_val({e.tag, ".cnt"},     32'(stall_count),  32'(e.cnt));
    endtask

    // Present one ID instruction for one cycle and check its outputs.
    task automatic step(input string tag, input logic v,
                        input logic [TB_AW-1:0] rs, input logic [TB_AW-1:0] rt,
                        input logic urs, input logic urt, input logic w, input logic m,
                        input logic [TB_AW-1:0] d,
                        input logic st, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [TB_CNT-1:0] cnt);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = w; id_m2reg = m; id_dest = d;
        push_exp(tag, st, fa, fb, cnt);
        pop_check();
    endtask

    // Shorthands: register-writing ALU op and load.
    task automatic alu(input string tag, input logic [TB_AW-1:0] rs, input logic [TB_AW-1:0] rt,
                       input logic urt, input logic [TB_AW-1:0] d, input logic st,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [TB_CNT-1:0] cnt);
        step(tag, 1'b1, rs, rt, 1'b1, urt, 1'b1, 1'b0, d, st, fa, fb, cnt);
    endtask

    task automatic lw(input string tag, input logic [TB_AW-1:0] base, input logic [TB_AW-1:0] d,
                      input logic st, input logic [1:0] fa, input logic [TB_CNT-1:0] cnt);
        step(tag, 1'b1, base, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, d, st, fa, 2'b00, cnt);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        id_valid = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; branch_taken = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0;

        // Reset: a load followed by its consumer must not stall while held.
        lw ("rst_lw",  5'd1, 5'd2, 1'b0, 2'b00, 3'd0);
        alu("rst_add", 5'd2, 5'd4, 1'b1, 5'd3, 1'b0, 2'b00, 2'b00, 3'd0);
        idle_cycle();
        resetn = 1'b1;

        // Load-use: one stall, then the load is forwarded from MEM.
        lw ("lu_lw",   5'd1, 5'd2, 1'b0, 2'b00, 3'd0);
        alu("lu_stl",  5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 2'b00, 2'b00, 3'd0);
        alu("lu_fwd",  5'd2, 5'd4, 1'b1, 5'd3, 1'b0, 2'b11, 2'b00, 3'd1);

        // ALU result forwarding from EXE, then from MEM.
        alu("ex_add",  5'd1, 5'd1, 1'b1, 5'd5, 1'b0, 2'b00, 2'b00, 3'd1);
        alu("ex_sub",  5'd5, 5'd5, 1'b1, 5'd6, 1'b0, 2'b01, 2'b01, 3'd1);
        alu("mem_ind", 5'd9, 5'd9, 1'b1, 5'd8, 1'b0, 2'b00, 2'b00, 3'd1);
        alu("mem_rd",  5'd6, 5'd6, 1'b1, 5'd10, 1'b0, 2'b10, 2'b10, 3'd1);

        // $0 never forwards.
        alu("z_wr",    5'd1, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 2'b00, 3'd1);
        alu("z_rd",    5'd0, 5'd0, 1'b1, 5'd11, 1'b0, 2'b00, 2'b00, 3'd1);

        // EXE wins over MEM for the same register.
        alu("pr_w1",   5'd1, 5'd1, 1'b1, 5'd7, 1'b0, 2'b00, 2'b00, 3'd1);
        alu("pr_w2",   5'd1, 5'd1, 1'b1, 5'd7, 1'b0, 2'b00, 2'b00, 3'd1);
        alu("pr_rd",   5'd7, 5'd7, 1'b1, 5'd12, 1'b0, 2'b01, 2'b01, 3'd1);

        // Use bit clear, then an invalid ID slot.
        alu("nouse",   5'd12, 5'd12, 1'b0, 5'd13, 1'b0, 2'b01, 2'b00, 3'd1);
        step("inval", 1'b0, 5'd13, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 5'd14,
             1'b0, 2'b00, 2'b00, 3'd1);

        // Back-to-back loads with dependencies: independent 1-cycle stalls.
        lw ("bb_lw1",  5'd1, 5'd14, 1'b0, 2'b00, 3'd1);
        lw ("bb_lw2s", 5'd14, 5'd15, 1'b1, 2'b00, 3'd1);
        lw ("bb_lw2f", 5'd14, 5'd15, 1'b0, 2'b11, 3'd2);
        alu("bb_adds", 5'd15, 5'd1, 1'b1, 5'd16, 1'b1, 2'b00, 2'b00, 3'd2);
        alu("bb_addf", 5'd15, 5'd1, 1'b1, 5'd16, 1'b0, 2'b11, 2'b00, 3'd3);

        // rs == rt, both dependent: a single stall.
        lw ("eq_lw",   5'd1, 5'd17, 1'b0, 2'b00, 3'd3);
        alu("eq_stl",  5'd17, 5'd17, 1'b1, 5'd18, 1'b1, 2'b00, 2'b00, 3'd3);
        alu("eq_fwd",  5'd17, 5'd17, 1'b1, 5'd18, 1'b0, 2'b11, 2'b11, 3'd4);

        // Reset during a stall: stall drops at once, scoreboard cleared.
        lw ("rs_lw",   5'd1, 5'd19, 1'b0, 2'b00, 3'd4);
        alu("rs_stl",  5'd19, 5'd2, 1'b1, 5'd20, 1'b1, 2'b00, 2'b00, 3'd4);
        #1;
        resetn = 1'b0;
        push_exp("rs_drop", 1'b0, 2'b00, 2'b00, 3'd0);
        pop_check();
        idle_cycle();
        idle_cycle();
        resetn = 1'b1;
        alu("rs_after", 5'd19, 5'd19, 1'b1, 5'd21, 1'b0, 2'b00, 2'b00, 3'd0);

        // Counter saturation at all-ones.
        for (int k = 0; k < 9; k++) begin
            lw ("sat_lw",  5'd1, 5'd22, 1'b0, 2'b00, TB_CNT'((k < 7) ? k : 7));
            alu("sat_stl", 5'd22, 5'd22, 1'b1, 5'd23, 1'b1, 2'b00, 2'b00,
                TB_CNT'((k < 7) ? k : 7));
            alu("sat_fwd", 5'd22, 5'd22, 1'b1, 5'd23, 1'b0, 2'b11, 2'b11,
                TB_CNT'((k + 1 < 7) ? k + 1 : 7));
        end

`ifdef HAZARD_BRANCH_FLUSH_EN
        // Taken branch beats a concurrent load-use.
        lw("br_lw", 5'd1, 5'd24, 1'b0, 2'b00, 3'd7);
        @(negedge clk);
        id_valid = 1'b1; id_rs = 5'd24; id_rt = 5'd24; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_wreg = 1'b1; id_m2reg = 1'b0; id_dest = 5'd25; branch_taken = 1'b1;
        #1;
        check_val("br.flush", 32'(ifid_flush), 32'd1);
        check_val("br.pc_we", 32'(pc_we),      32'd1);
        check_val("br.cnt",   32'(stall_count), 32'd7);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check_val("br.noflush", 32'(ifid_flush), 32'd0);
        check_val("br.e_zero",  32'(fwda),       32'(2'b11));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
